pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Central hazard and sequencing controller for the 5-stage 64-bit pipeline. It generates the write-enable, hold and flush controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers from three sources: load-use hazards, taken branches resolved at the MEM stage, and a data-memory wait-state handshake. It also guards the memory wait with a timeout and keeps saturating stall/flush statistics. All stage registers take their stall/flush controls only from this block.

## Interface
- TIMEOUT, 16: max consecutive MEM_WAIT cycles before error; legal range 2..65535
- clk  in  1  pipeline clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low; 0 forces all state to reset values immediately
- IFID_rs1, IFID_rs2  in  5 each  source registers of instruction in ID
- IDEX_rd  in  5  destination of instruction in EX
- IDEX_MemRead  in  1  instruction in EX is a load
- EM_MemRead, EM_MemWrite  in  1 each  instruction in MEM accesses data memory
- branch_taken  in  1  MEM-stage branch resolved taken (Branch_2 & branch_op1)
- mem_ready  in  1  data memory completes the access this cycle
- pc_write  out  1  PC may update
- pc_src  out  1  1 = PC loads branch target
- ifid_write  out  1  IF/ID may update
- ifid_flush, idex_flush, exmem_flush  out  1 each  load bubble (zeros) into that register
- idex_hold, exmem_hold  out  1 each  register keeps its value
- memwb_bubble  out  1  MEM/WB loads a bubble
- mem_err  out  1  sticky memory-timeout error
- stall_cycles  out  16  saturating count of cycles with pc_write=0
- flush_count  out  8  saturating count of branch flushes

## Operation
- Registered state: FSM {RUN, MEM_WAIT, ERR}, wait_cnt[15:0], mem_err, stall_cycles, flush_count. Control outputs are combinational from state and inputs, so they act at the next edge.
- Define mem_acc = EM_MemRead | EM_MemWrite; freeze = pc_write=0, ifid_write=0, idex_hold=1, exmem_hold=1, memwb_bubble=1, all flushes 0, pc_src=0.
- Default (no event): pc_write=1, ifid_write=1, every other control 0.
- Priority, highest first: ERR > memory wait > branch flush > load-use stall.
- RUN:
  - mem_acc & !mem_ready: freeze; next MEM_WAIT, wait_cnt<=1.
  - Otherwise, if branch_taken: pc_write=1, pc_src=1, ifid_flush=idex_flush=exmem_flush=1; flush_count++.
  - Otherwise, if load-use (IDEX_MemRead & IDEX_rd!=0 & (IDEX_rd==IFID_rs1 | IDEX_rd==IFID_rs2)): pc_write=0, ifid_write=0, idex_flush=1.
- MEM_WAIT:
  - mem_ready=1: outputs as in RUN with the memory condition treated as satisfied (branch/load-use evaluated normally); next RUN, wait_cnt<=0.
  - mem_ready=0: freeze; wait_cnt++; if wait_cnt==TIMEOUT-1 then next ERR, mem_err<=1.
- ERR: freeze permanently; only reset exits.
- Counters saturate at all-ones (0xFFFF, 0xFF) and never wrap. stall_cycles increments on every cycle with pc_write=0, including freeze and ERR cycles.

## Timing
- Reset values: state=RUN, wait_cnt=0, mem_err=0, stall_cycles=0, flush_count=0. With no events asserted, outputs are pc_write=1, ifid_write=1, all others 0.
- Reset asserted mid-MEM_WAIT or in ERR returns to RUN asynchronously. The first edge after deassertion behaves as RUN.
- Zero-cycle latency from inputs to controls. A memory access with mem_ready=1 in its first MEM cycle causes no stall.
- An access that sees mem_ready after N wait cycles stalls the pipeline N cycles (N = cycles spent in MEM_WAIT including the RUN entry cycle).
- Branch with simultaneous memory wait: the flush is deferred. branch_taken stays valid because EX/MEM is held, and the flush fires in the cycle mem_ready arrives.
- Branch with simultaneous load-use: the branch wins; idex_flush=1 from the branch; pc_write=1.
- Load-use with IDEX_rd=0 never stalls.

## Test plan
- Load-use: IDEX_MemRead=1, IDEX_rd=5, IFID_rs2=5 -> pc_write=0, ifid_write=0, idex_flush=1 for one cycle; stall_cycles=1.
- Branch: branch_taken=1 with no memory access -> pc_src=1, ifid/idex/exmem_flush=1; flush_count 0->1. Same cycle with load-use asserted -> pc_write=1.
- Memory wait: EM_MemRead=1, mem_ready low 3 cycles then high -> freeze for 3 cycles, release on the ready cycle, state back to RUN; stall_cycles=3.
- Timeout with TIMEOUT=4, mem_ready held 0 -> ERR entered after 4 frozen cycles, mem_err=1 sticky. Async reset low -> mem_err=0 and state RUN without a clock edge.
- Branch during wait: branch_taken=1 and EM_MemWrite=1 with mem_ready=0 for 2 cycles -> no flush while frozen; flushes plus pc_src=1 fire in the ready cycle.
- Saturation: 70000 forced stall cycles -> stall_cycles holds at 0xFFFF. 300 branches -> flush_count holds at 0xFF.

Source files
------------

// File: rtl/pipeline_ctrl_if.sv
// Hazard-controller bundle: hazard/memory status from the datapath, stage controls and stats back.
// master = pipeline datapath side, slave = pipeline_ctrl.
interface pipeline_ctrl_if;
  logic [4:0]  IFID_rs1;
  logic [4:0]  IFID_rs2;
  logic [4:0]  IDEX_rd;
  logic        IDEX_MemRead;
  logic        EM_MemRead;
  logic        EM_MemWrite;
  logic        branch_taken;
  logic        mem_ready;

  logic        pc_write;
  logic        pc_src;
  logic        ifid_write;
  logic        ifid_flush;
  logic        idex_flush;
  logic        exmem_flush;
  logic        idex_hold;
  logic        exmem_hold;
  logic        memwb_bubble;
  logic        mem_err;
  logic [15:0] stall_cycles;
  logic [7:0]  flush_count;

  modport master (
    output IFID_rs1, IFID_rs2, IDEX_rd, IDEX_MemRead, EM_MemRead, EM_MemWrite,
           branch_taken, mem_ready,
    input  pc_write, pc_src, ifid_write, ifid_flush, idex_flush, exmem_flush,
           idex_hold, exmem_hold, memwb_bubble, mem_err, stall_cycles, flush_count
  );

  modport slave (
    input  IFID_rs1, IFID_rs2, IDEX_rd, IDEX_MemRead, EM_MemRead, EM_MemWrite,
           branch_taken, mem_ready,
    output pc_write, pc_src, ifid_write, ifid_flush, idex_flush, exmem_flush,
           idex_hold, exmem_hold, memwb_bubble, mem_err, stall_cycles, flush_count
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/sequencing controller: controls are combinational (zero latency) from state and inputs;
// a pending data-memory access freezes every stage until mem_ready, with a timeout into a sticky error.
module pipeline_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  pipeline_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

  localparam logic [15:0] LP_WAIT_LAST = 16'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next_state;
  logic [15:0] r_wait_cnt;
  logic [15:0] w_wait_cnt_nxt;
  logic        r_mem_err;
  logic        w_set_err;
  logic [15:0] r_stall_cycles;
  logic [7:0]  r_flush_count;

  logic        w_mem_acc;
  logic        w_load_use;
  logic        w_freeze;
  logic        w_resolve;

  logic        w_pc_write;
  logic        w_pc_src;
  logic        w_ifid_write;
  logic        w_ifid_flush;
  logic        w_idex_flush;
  logic        w_exmem_flush;
  logic        w_idex_hold;
  logic        w_exmem_hold;
  logic        w_memwb_bubble;

  assign w_mem_acc  = bus.EM_MemRead | bus.EM_MemWrite;
  assign w_load_use = bus.IDEX_MemRead && (bus.IDEX_rd != 5'd0) &&
                      ((bus.IDEX_rd == bus.IFID_rs1) || (bus.IDEX_rd == bus.IFID_rs2));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= RUN;
      r_wait_cnt <= 16'd0;
    end else begin
      r_state    <= w_next_state;
      r_wait_cnt <= w_wait_cnt_nxt;
    end
  end

  always_comb begin
    w_next_state   = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    w_set_err      = 1'b0;
    w_freeze       = 1'b0;
    w_resolve      = 1'b0;

    case (r_state)
      RUN: begin
        if (w_mem_acc && !bus.mem_ready) begin
          w_freeze       = 1'b1;
          w_next_state   = MEM_WAIT;
          w_wait_cnt_nxt = 16'd1;
        end else begin
          w_resolve = 1'b1;
        end
      end
      MEM_WAIT: begin
        // EX/MEM is held while waiting, so a deferred branch is still valid here.
        if (bus.mem_ready) begin
          w_resolve      = 1'b1;
          w_next_state   = RUN;
          w_wait_cnt_nxt = 16'd0;
        end else begin
          w_freeze       = 1'b1;
          w_wait_cnt_nxt = r_wait_cnt + 16'd1;
          if (r_wait_cnt == LP_WAIT_LAST) begin
            w_next_state = ERR;
            w_set_err    = 1'b1;
          end
        end
      end
      ERR: begin
        w_freeze = 1'b1;
      end
      default: begin
        w_freeze     = 1'b1;
        w_next_state = ERR;
      end
    endcase
  end

  always_comb begin
    w_pc_write     = 1'b1;
    w_pc_src       = 1'b0;
    w_ifid_write   = 1'b1;
    w_ifid_flush   = 1'b0;
    w_idex_flush   = 1'b0;
    w_exmem_flush  = 1'b0;
    w_idex_hold    = 1'b0;
    w_exmem_hold   = 1'b0;
    w_memwb_bubble = 1'b0;

    if (w_freeze) begin
      w_pc_write     = 1'b0;
      w_ifid_write   = 1'b0;
      w_idex_hold    = 1'b1;
      w_exmem_hold   = 1'b1;
      w_memwb_bubble = 1'b1;
    end else if (w_resolve) begin
      if (bus.branch_taken) begin
        w_pc_src      = 1'b1;
        w_ifid_flush  = 1'b1;
        w_idex_flush  = 1'b1;
        w_exmem_flush = 1'b1;
      end else if (w_load_use) begin
        w_pc_write   = 1'b0;
        w_ifid_write = 1'b0;
        w_idex_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mem_err      <= 1'b0;
      r_stall_cycles <= 16'd0;
      r_flush_count  <= 8'd0;
    end else begin
      if (w_set_err) begin
        r_mem_err <= 1'b1;
      end
      if (!w_pc_write && (r_stall_cycles != 16'hFFFF)) begin
        r_stall_cycles <= r_stall_cycles + 16'd1;
      end
      if (w_pc_src && (r_flush_count != 8'hFF)) begin
        r_flush_count <= r_flush_count + 8'd1;
      end
    end
  end

  assign bus.pc_write     = w_pc_write;
  assign bus.pc_src       = w_pc_src;
  assign bus.ifid_write   = w_ifid_write;
  assign bus.ifid_flush   = w_ifid_flush;
  assign bus.idex_flush   = w_idex_flush;
  assign bus.exmem_flush  = w_exmem_flush;
  assign bus.idex_hold    = w_idex_hold;
  assign bus.exmem_hold   = w_exmem_hold;
  assign bus.memwb_bubble = w_memwb_bubble;
  assign bus.mem_err      = r_mem_err;
  assign bus.stall_cycles = r_stall_cycles;
  assign bus.flush_count  = r_flush_count;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: control-vector table, multi-cycle corner sequences, random run against a model.
module tb_pipeline_ctrl;
  localparam int TMO = 4;
  // {pc_write, pc_src, ifid_write, ifid_flush, idex_flush, exmem_flush, idex_hold, exmem_hold, memwb_bubble}
  localparam logic [8:0] C_DEF = 9'b101000000;
  localparam logic [8:0] C_LU  = 9'b000010000;
  localparam logic [8:0] C_BR  = 9'b111111000;
  localparam logic [8:0] C_FRZ = 9'b000000111;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;

  pipeline_ctrl_if bus();
  pipeline_ctrl #(.TIMEOUT(TMO)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rs1, rs2, rd;
    logic       idmr, emr, emw, br, rdy;
    logic [8:0] exp;
  } vec_t;
  vec_t tbl[13];

  int m_pend, m_stall, m_flush;
  bit m_err;

  function automatic logic [8:0] ctrl_now();
    return {bus.pc_write, bus.pc_src, bus.ifid_write, bus.ifid_flush, bus.idex_flush,
            bus.exmem_flush, bus.idex_hold, bus.exmem_hold, bus.memwb_bubble};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got %0h want %0h", name, $time, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic idmr, input logic emr, input logic emw,
                       input logic br, input logic rdy);
    bus.IFID_rs1     = rs1;
    bus.IFID_rs2     = rs2;
    bus.IDEX_rd      = rd;
    bus.IDEX_MemRead = idmr;
    bus.EM_MemRead   = emr;
    bus.EM_MemWrite  = emw;
    bus.branch_taken = br;
    bus.mem_ready    = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ctrl_is(input string name, input logic [8:0] e);
    #2;
    chk(name, 32'(ctrl_now()), 32'(e));
  endtask

  task automatic do_reset();
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    reset = 1'b0;
    #2;
    reset = 1'b1;
    tick();
    m_pend = 0; m_stall = 0; m_flush = 0; m_err = 0;
  endtask

  initial begin
    tbl[0]  = '{5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, C_DEF};
    tbl[1]  = '{5'd1, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, C_LU};
    tbl[2]  = '{5'd5, 5'd7, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, C_LU};
    tbl[3]  = '{5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, C_DEF};
    tbl[4]  = '{5'd5, 5'd5, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, C_DEF};
    tbl[5]  = '{5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, C_BR};
    tbl[6]  = '{5'd5, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, C_BR};
    tbl[7]  = '{5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, C_DEF};
    tbl[8]  = '{5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, C_FRZ};
    tbl[9]  = '{5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, C_BR};
    tbl[10] = '{5'd5, 5'd2, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, C_FRZ};
    tbl[11] = '{5'd5, 5'd2, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, C_LU};
    tbl[12] = '{5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_DEF};

    // Reset state, observed while reset is held low.
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    #1 reset = 1'b0;
    #1;
    chk("rst_ctrl", 32'(ctrl_now()), 32'(C_DEF));
    chk("rst_err", 32'(bus.mem_err), 32'd0);
    chk("rst_stall", 32'(bus.stall_cycles), 32'd0);
    chk("rst_flush", 32'(bus.flush_count), 32'd0);
    reset = 1'b1;
    tick();

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].idmr, tbl[i].emr, tbl[i].emw,
            tbl[i].br, tbl[i].rdy);
      ctrl_is($sformatf("tbl%0d", i), tbl[i].exp);
      tick();
    end
    chk("tbl_stall", 32'(bus.stall_cycles), 32'd5);
    chk("tbl_flush", 32'(bus.flush_count), 32'd3);

    // Memory wait: three not-ready cycles, released on the ready cycle.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      ctrl_is($sformatf("wait_frz%0d", i), C_FRZ);
      tick();
    end
    drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    ctrl_is("wait_release", C_DEF);
    tick();
    chk("wait_stall", 32'(bus.stall_cycles), 32'd3);
    drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    ctrl_is("wait_back_run", C_DEF);
    tick();

    // Branch arriving during a memory wait is deferred to the ready cycle.
    do_reset();
    for (int i = 0; i < 2; i++) begin
      drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      ctrl_is($sformatf("brwait_frz%0d", i), C_FRZ);
      tick();
    end
    chk("brwait_noflush", 32'(bus.flush_count), 32'd0);
    drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    ctrl_is("brwait_fire", C_BR);
    tick();
    chk("brwait_flush", 32'(bus.flush_count), 32'd1);
    chk("brwait_stall", 32'(bus.stall_cycles), 32'd2);

    // Timeout into ERR, then asynchronous reset out of it.
    do_reset();
    for (int i = 0; i < TMO; i++) begin
      drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      ctrl_is($sformatf("tmo_frz%0d", i), C_FRZ);
      chk($sformatf("tmo_err_pre%0d", i), 32'(bus.mem_err), 32'd0);
      tick();
    end
    chk("tmo_err", 32'(bus.mem_err), 32'd1);
    drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    ctrl_is("err_frozen", C_FRZ);
    tick();
    chk("err_sticky", 32'(bus.mem_err), 32'd1);
    chk("err_stall", 32'(bus.stall_cycles), 32'd5);
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    reset = 1'b0;
    #1;
    chk("arst_err", 32'(bus.mem_err), 32'd0);
    chk("arst_stall", 32'(bus.stall_cycles), 32'd0);
    chk("arst_ctrl", 32'(ctrl_now()), 32'(C_DEF));
    drive(5'd5, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    #1 reset = 1'b1;
    ctrl_is("arst_lu", C_LU);
    tick();
    chk("arst_lu_stall", 32'(bus.stall_cycles), 32'd1);

    // Saturation of both statistics counters.
    do_reset();
    drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 70000; i++) tick();
    chk("sat_stall", 32'(bus.stall_cycles), 32'hFFFF);
    do_reset();
    drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 300; i++) tick();
    chk("sat_flush", 32'(bus.flush_count), 32'hFF);
    chk("sat_flush_nostall", 32'(bus.stall_cycles), 32'd0);

    // Random traffic against a rule-level model: a frozen cycle is any not-ready cycle while
    // an access is pending; TMO consecutive frozen cycles of one access is a timeout.
    for (int i = 0; i < 3000; i++) begin
      logic [4:0] rs1, rs2, rd;
      logic idmr, emr, emw, br, rdy, acc, lu, frozen;
      logic [8:0] e;
      if (i % 500 == 0) do_reset();
      rs1  = 5'($urandom_range(0, 3));
      rs2  = 5'($urandom_range(0, 3));
      rd   = 5'($urandom_range(0, 3));
      idmr = ($urandom_range(0, 1) == 1);
      emr  = ($urandom_range(0, 4) == 0);
      emw  = ($urandom_range(0, 6) == 0);
      br   = ($urandom_range(0, 4) == 0);
      rdy  = ($urandom_range(0, 3) != 0);
      drive(rs1, rs2, rd, idmr, emr, emw, br, rdy);
      acc    = emr | emw;
      lu     = idmr && (rd != 0) && (rd == rs1 || rd == rs2);
      frozen = m_err || ((m_pend > 0 || acc) && !rdy);
      e = frozen ? C_FRZ : (br ? C_BR : (lu ? C_LU : C_DEF));
      ctrl_is("rand_ctrl", e);
      tick();
      if (frozen) begin
        if (m_stall < 65535) m_stall++;
        m_pend++;
        if (m_pend >= TMO) m_err = 1;
      end else begin
        m_pend = 0;
        if (br) begin
          if (m_flush < 255) m_flush++;
        end else if (lu) begin
          if (m_stall < 65535) m_stall++;
        end
      end
      chk("rand_err", 32'(bus.mem_err), 32'(m_err));
      chk("rand_stall", 32'(bus.stall_cycles), 32'(m_stall));
      chk("rand_flush", 32'(bus.flush_count), 32'(m_flush));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
